// File: rtl/pipe_pkg.sv
// Shared types and constants for the IF/ID pipeline stage register.
package pipe_pkg;

  localparam int unsigned PC_W_DEFAULT    = 32;
  localparam int unsigned INSTR_W_DEFAULT = 32;
  localparam logic [INSTR_W_DEFAULT-1:0] NOP_INSTR_DEFAULT = 32'hE000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  typedef struct packed {
    logic [PC_W_DEFAULT-1:0]    pc;
    logic [INSTR_W_DEFAULT-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF->ID stage register with valid/ready on both sides, freeze and flush.
// Define IF_ID_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module if_id_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        PC_W      = PC_W_DEFAULT,
  parameter int unsigned        INSTR_W   = INSTR_W_DEFAULT,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } payload_t;

  localparam payload_t EMPTY_PAYLOAD = payload_t'({{PC_W{1'b0}}, NOP_INSTR});

  stage_state_t state_q, state_d;
  payload_t     main_q;
  payload_t     in_payload;
  logic         out_valid_int;
  logic         in_fire, out_fire;
  logic         load_main_in, clear_main;

  assign in_payload    = '{pc: in_pc, instr: in_instr};
  assign out_valid_int = (state_q != EMPTY);
  assign out_valid     = out_valid_int & ~freeze;

`ifdef IF_ID_SKID_EN
  payload_t skid_q;
  logic     load_skid, load_main_skid;

  // Registered-only in_ready: no path from out_ready.
  assign in_ready = (state_q != TWO) & ~freeze;
`else
  assign in_ready = (~out_valid_int | out_ready) & ~freeze;
`endif

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next-state and register-update selects; freeze holds, flush empties.
  always_comb begin
    state_d      = state_q;
    load_main_in = 1'b0;
    clear_main   = 1'b0;
`ifdef IF_ID_SKID_EN
    load_skid      = 1'b0;
    load_main_skid = 1'b0;
`endif
    if (freeze) begin
      state_d = state_q;
    end else if (flush) begin
      state_d    = EMPTY;
      clear_main = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
`ifdef IF_ID_SKID_EN
          end else if (in_fire) begin
            state_d   = TWO;
            load_skid = 1'b1;
`else
          end else if (in_fire) begin
            load_main_in = 1'b1;
`endif
          end else if (out_fire) begin
            state_d    = EMPTY;
            clear_main = 1'b1;
          end
        end
`ifdef IF_ID_SKID_EN
        TWO: begin
          if (out_fire) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
`endif
        default: begin
          state_d    = EMPTY;
          clear_main = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= EMPTY_PAYLOAD;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        main_q <= in_payload;
`ifdef IF_ID_SKID_EN
      end else if (load_main_skid) begin
        main_q <= skid_q;
`endif
      end else if (clear_main) begin
        main_q <= EMPTY_PAYLOAD;
      end
    end
  end

`ifdef IF_ID_SKID_EN
  // Skid entry is cleared whenever the stage is emptied so no stale data lingers.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_q <= EMPTY_PAYLOAD;
    end else if (load_skid) begin
      skid_q <= in_payload;
    end else if (clear_main || load_main_skid) begin
      skid_q <= EMPTY_PAYLOAD;
    end
  end
`endif

  assign out_pc    = main_q.pc;
  assign out_instr = main_q.instr;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Self-checking bench for if_id_pipe_reg: directed scenarios then random traffic
// against a queue-based reference model (capacity 2 with IF_ID_SKID_EN, else 1).
module tb_if_id_pipe_reg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'hE000_0000;
`ifdef IF_ID_SKID_EN
  localparam int CAP  = 2;
  localparam bit SKID = 1'b1;
`else
  localparam int CAP  = 1;
  localparam bit SKID = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst, freeze, flush, in_valid, in_ready, out_valid, out_ready;
  logic [PC_W-1:0]    in_pc, out_pc;
  logic [INSTR_W-1:0] in_instr, out_instr;

  if_id_pipe_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ent_t;

  ent_t q[$];
  bit   known = 1'b0;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check outputs, advance model at posedge.
  task automatic cycle(input logic r, input logic fz, input logic fl, input logic iv,
                       input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins,
                       input logic ordy);
    bit e_ir, e_ov, ifire, ofire;
    ent_t e;
    @(negedge clk);
    rst = r; freeze = fz; flush = fl; in_valid = iv; in_pc = pc; in_instr = ins;
    out_ready = ordy;
    #1;
    e_ov = (q.size() > 0) && !fz;
    if (SKID) e_ir = (q.size() < CAP) && !fz;
    else      e_ir = ((q.size() == 0) || ordy) && !fz;
    if (known) begin
      check("in_ready",  64'(in_ready),  64'(e_ir));
      check("out_valid", 64'(out_valid), 64'(e_ov));
      check("out_pc",    64'(out_pc),    (q.size() > 0) ? 64'(q[0].pc)    : 64'(0));
      check("out_instr", 64'(out_instr), (q.size() > 0) ? 64'(q[0].instr) : 64'(NOP));
    end
    ifire = iv && e_ir;
    ofire = e_ov && ordy;
    @(posedge clk);
    if (r) begin
      q.delete();
      known = 1'b1;
    end else if (fz) begin
      // hold
    end else if (fl) begin
      q.delete();
    end else begin
      if (ofire) void'(q.pop_front());
      if (ifire) begin
        e.pc = pc; e.instr = ins;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, ordy);
  endtask

  task automatic push(input logic [PC_W-1:0] pc, input logic ordy);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, pc, 32'hE3A0_0000 | INSTR_W'(pc), ordy);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_pc = '0; in_instr = '0; out_ready = 1'b0;

    // Reset for two cycles, then explicit reset-value checks.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_pc",    64'(out_pc),    64'(0));
    check("rst_out_instr", 64'(out_instr), 64'(32'hE000_0000));
    check("rst_in_ready",  64'(in_ready),  64'(1));

    // Stream at full rate with decode always ready.
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b0, 1'b0, 1'b1, PC_W'(4 * i), 32'hE3A0_1001 + INSTR_W'(i), 1'b1);
    idle(1'b1);

    // Back-pressure: fill, offer a third, then drain.
    push(32'h10, 1'b0);
    push(32'h14, 1'b0);
    push(32'h18, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Flush drops the held entry and the concurrent input.
    push(32'h20, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h24, 32'hE3A0_0024, 1'b1);
    idle(1'b1);

    // Freeze hides the entry and blocks input; release restores it.
    push(32'h30, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h34, 32'hE3A0_0034, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h34, 32'hE3A0_0034, 1'b1);
    idle(1'b0);
    idle(1'b1);

    // Freeze wins over flush; a later flush empties the stage.
    push(32'h40, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b1);
    idle(1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    idle(1'b1);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 127) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 2) != 0),
            PC_W'($urandom), INSTR_W'($urandom),
            ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
